maze_player: RTL and testbench

//  Player-movement stage downstream of the maze generator. Consumes the finished wall maps and

---
 rtl/maze_player.sv | 178 +++++++++++++++++
 tb/tb_maze_player.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/maze_player.sv
// Player-movement stage: walks a token through the 10x15 maze, blocks wall moves, counts moves, flags exit.
// Latency: a request updates position/count/won/bump at the next clock edge (1 cycle).
// Backpressure: none; maze_busy overrides everything and returns the player to start.
module maze_player #(
  parameter int START_X    = 0,
  parameter int START_Y    = 0,
  parameter int EXIT_X     = 9,
  parameter int EXIT_Y     = 14,
  parameter int REPEAT_CYC = 2000000,
  parameter int REPEAT_W   = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         maze_busy,
  input  logic [159:0] h_walls,
  input  logic [164:0] v_walls,
  input  logic         btn_up,
  input  logic         btn_right,
  input  logic         btn_down,
  input  logic         btn_left,
  output logic [3:0]   player_x,
  output logic [3:0]   player_y,
  output logic [15:0]  move_count,
  output logic         won,
  output logic         bump
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_PLAY = 2'd1,
    ST_WON  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          x_q, x_d;
  logic [3:0]          y_q, y_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                won_q, won_d;
  logic                bump_q, bump_d;
  logic [REPEAT_W-1:0] rep_q, rep_d;
  logic [3:0]          btn_prev_q, btn_prev_d;

  // Buttons packed as {up, right, down, left}.
  logic [3:0]          btn;
  logic                btn_onehot;
  logic [REPEAT_W-1:0] rep_inc;

  // Wall-map indices for the current cell; 8 bits covers the largest index (164).
  logic [7:0] x8, y8;
  logic [7:0] idx_up, idx_dn, idx_vl, idx_vr;

  logic       mv_legal;
  logic [3:0] nx, ny;
  logic       fire;

  assign btn        = {btn_up, btn_right, btn_down, btn_left};
  assign btn_onehot = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
  assign rep_inc    = rep_q + REPEAT_W'(1);

  assign x8     = {4'd0, x_q};
  assign y8     = {4'd0, y_q};
  assign idx_up = (y8 << 3) + (y8 << 1) + x8;   // y*10 + x: wall above the cell
  assign idx_dn = idx_up + 8'd10;               // (y+1)*10 + x: wall below the cell
  assign idx_vl = idx_up + y8;                  // y*11 + x: wall left of the cell
  assign idx_vr = idx_vl + 8'd1;                // wall right of the cell

  // Target cell and legality for whichever single button is pressed; bounds checked explicitly.
  always_comb begin
    mv_legal = 1'b0;
    nx       = x_q;
    ny       = y_q;
    if (btn_up) begin
      mv_legal = (y_q != 4'd0) && !h_walls[idx_up];
      ny       = y_q - 4'd1;
    end else if (btn_right) begin
      mv_legal = (x_q != 4'd9) && !v_walls[idx_vr];
      nx       = x_q + 4'd1;
    end else if (btn_down) begin
      mv_legal = (y_q != 4'd14) && !h_walls[idx_dn];
      ny       = y_q + 4'd1;
    end else if (btn_left) begin
      mv_legal = (x_q != 4'd0) && !v_walls[idx_vl];
      nx       = x_q - 4'd1;
    end
  end

  // Next-state logic: game FSM, press/auto-repeat detection and move execution.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    won_d      = won_q;
    bump_d     = 1'b0;
    rep_d      = '0;
    btn_prev_d = btn;
    fire       = 1'b0;

    unique case (state_q)
      ST_WAIT: begin
        if (!maze_busy) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (maze_busy) begin
          // A new maze is coming: any same-cycle request is dropped.
          state_d = ST_WAIT;
          x_d     = 4'(START_X);
          y_d     = 4'(START_Y);
          cnt_d   = 16'd0;
          won_d   = 1'b0;
        end else begin
          if (btn != btn_prev_q) begin
            fire = btn_onehot;
          end else if (btn_onehot) begin
            if (rep_inc == REPEAT_W'(REPEAT_CYC)) begin
              fire = 1'b1;
            end else begin
              rep_d = rep_inc;
            end
          end
          if (fire) begin
            if (mv_legal) begin
              x_d = nx;
              y_d = ny;
              if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
              if ((nx == 4'(EXIT_X)) && (ny == 4'(EXIT_Y))) begin
                won_d   = 1'b1;
                state_d = ST_WON;
              end
            end else begin
              bump_d = 1'b1;
            end
          end
        end
      end
      ST_WON: begin
        if (maze_busy) begin
          state_d = ST_WAIT;
          x_d     = 4'(START_X);
          y_d     = 4'(START_Y);
          cnt_d   = 16'd0;
          won_d   = 1'b0;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_WAIT;
      x_q        <= 4'(START_X);
      y_q        <= 4'(START_Y);
      cnt_q      <= 16'd0;
      won_q      <= 1'b0;
      bump_q     <= 1'b0;
      rep_q      <= '0;
      btn_prev_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      won_q      <= won_d;
      bump_q     <= bump_d;
      rep_q      <= rep_d;
      btn_prev_q <= btn_prev_d;
    end
  end

  assign player_x   = x_q;
  assign player_y   = y_q;
  assign move_count = cnt_q;
  assign won        = won_q;
  assign bump       = bump_q;

endmodule

// File: tb/tb_maze_player.sv
// Directed bench for maze_player: expected outputs queued per step, popped and compared after each edge.
// Runs with a short auto-repeat period so held-button behaviour fits in a few cycles.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same offset.
module tb_maze_player;

  localparam logic [3:0] UP    = 4'b1000;
  localparam logic [3:0] RIGHT = 4'b0100;
  localparam logic [3:0] DOWN  = 4'b0010;
  localparam logic [3:0] LEFT  = 4'b0001;

  logic         clk = 1'b0;
  logic         rst;
  logic         maze_busy;
  logic [159:0] h_walls;
  logic [164:0] v_walls;
  logic [3:0]   btns;
  logic [3:0]   player_x, player_y;
  logic [15:0]  move_count;
  logic         won, bump;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string tag;
    int    x;
    int    y;
    int    c;
    int    w;
    int    b;
  } exp_t;

  exp_t exp_q[$];

  maze_player #(
    .START_X(0), .START_Y(0), .EXIT_X(9), .EXIT_Y(14),
    .REPEAT_CYC(4), .REPEAT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .maze_busy(maze_busy),
    .h_walls(h_walls),
    .v_walls(v_walls),
    .btn_up(btns[3]),
    .btn_right(btns[2]),
    .btn_down(btns[1]),
    .btn_left(btns[0]),
    .player_x(player_x),
    .player_y(player_y),
    .move_count(move_count),
    .won(won),
    .bump(bump)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input int x, input int y, input int c,
                          input int w, input int b);
    exp_t e;
    e.tag = tag; e.x = x; e.y = y; e.c = c; e.w = w; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = exp_q.pop_front();
    chk({e.tag, ".x"},     int'(player_x),   e.x);
    chk({e.tag, ".y"},     int'(player_y),   e.y);
    chk({e.tag, ".count"}, int'(move_count), e.c);
    chk({e.tag, ".won"},   int'(won),        e.w);
    chk({e.tag, ".bump"},  int'(bump),       e.b);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Queue the expectation for the inputs just driven, clock once, then compare.
  task automatic cyc_expect(input string tag, input int x, input int y, input int c,
                            input int w, input int b);
    push_exp(tag, x, y, c, w, b);
    cyc();
    check_out();
  endtask

  // One-cycle press followed by a release cycle; bump must be gone after release.
  task automatic press(input logic [3:0] b, input string tag, input int x, input int y,
                       input int c, input int w, input int bm);
    btns = b;
    cyc_expect(tag, x, y, c, w, bm);
    btns = 4'd0;
    cyc_expect({tag, "_rel"}, x, y, c, w, 0);
  endtask

  initial begin
    rst       = 1'b1;
    maze_busy = 1'b1;
    h_walls   = '0;
    v_walls   = '0;
    btns      = 4'd0;
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", 0, 0, 0, 0, 0);
    check_out();
    rst = 1'b1;

    // WAIT holds while busy; buttons ignored.
    cyc_expect("wait_hold", 0, 0, 0, 0, 0);
    press(RIGHT, "wait_ign", 0, 0, 0, 0, 0);

    // WAIT -> PLAY on the first non-busy cycle.
    maze_busy = 1'b0;
    cyc_expect("to_play", 0, 0, 0, 0, 0);

    // Open maze: three separate right presses.
    press(RIGHT, "right1", 1, 0, 1, 0, 0);
    press(RIGHT, "right2", 2, 0, 2, 0, 0);
    press(RIGHT, "right3", 3, 0, 3, 0, 0);

    // New maze returns to start.
    maze_busy = 1'b1;
    cyc_expect("busy_reset", 0, 0, 0, 0, 0);
    maze_busy = 1'b0;
    cyc_expect("replay", 0, 0, 0, 0, 0);

    // Wall right of (0,0): bump for exactly one cycle even while held.
    v_walls[1] = 1'b1;
    btns = RIGHT;
    cyc_expect("wall_right_bump", 0, 0, 0, 0, 1);
    cyc_expect("wall_right_one", 0, 0, 0, 0, 0);
    btns = 4'd0;
    cyc_expect("wall_right_rel", 0, 0, 0, 0, 0);
    v_walls = '0;

    // Bound checks at (0,0) with no walls set.
    press(UP,   "bound_up",   0, 0, 0, 0, 1);
    press(LEFT, "bound_left", 0, 0, 0, 0, 1);

    // Hold down: move on the first cycle, then every 4 cycles.
    btns = DOWN;
    for (int k = 1; k <= 20; k++) begin
      cyc_expect($sformatf("hold_down_%0d", k), 0, (k - 1) / 4 + 1, (k - 1) / 4 + 1, 0, 0);
    end
    btns = 4'd0;
    cyc_expect("hold_rel", 0, 5, 5, 0, 0);

    // Walk to (3,3).
    press(UP,    "up_a",    0, 4, 6, 0, 0);
    press(UP,    "up_b",    0, 3, 7, 0, 0);
    press(RIGHT, "right_a", 1, 3, 8, 0, 0);
    press(RIGHT, "right_b", 2, 3, 9, 0, 0);
    press(RIGHT, "right_c", 3, 3, 10, 0, 0);

    // Multiple buttons: no request, no bump.
    btns = UP | LEFT;
    cyc_expect("two_btn_a", 3, 3, 10, 0, 0);
    cyc_expect("two_btn_b", 3, 3, 10, 0, 0);
    btns = UP | RIGHT | DOWN;
    cyc_expect("three_btn", 3, 3, 10, 0, 0);
    btns = 4'd0;
    cyc();

    // Walls on all four sides of (3,3) exercise every index formula.
    h_walls[33] = 1'b1;
    h_walls[43] = 1'b1;
    v_walls[36] = 1'b1;
    v_walls[37] = 1'b1;
    press(UP,    "wall_up",    3, 3, 10, 0, 1);
    press(DOWN,  "wall_down",  3, 3, 10, 0, 1);
    press(LEFT,  "wall_left",  3, 3, 10, 0, 1);
    press(RIGHT, "wall_right", 3, 3, 10, 0, 1);
    h_walls = '0;
    v_walls = '0;

    // Walk to the exit.
    for (int i = 1; i <= 6; i++) begin
      press(RIGHT, $sformatf("to_exit_r%0d", i), 3 + i, 3, 10 + i, 0, 0);
    end
    for (int i = 1; i <= 11; i++) begin
      press(DOWN, $sformatf("to_exit_d%0d", i), 9, 3 + i, 16 + i, (i == 11) ? 1 : 0, 0);
    end

    // WON ignores buttons and never bumps.
    press(LEFT, "won_ign_left", 9, 14, 27, 1, 0);
    press(DOWN, "won_ign_down", 9, 14, 27, 1, 0);

    // New maze clears the win.
    maze_busy = 1'b1;
    cyc_expect("won_busy", 0, 0, 0, 0, 0);
    btns = RIGHT;
    cyc_expect("won_wait_ign", 0, 0, 0, 0, 0);
    btns = 4'd0;
    maze_busy = 1'b0;
    cyc_expect("won_replay", 0, 0, 0, 0, 0);
    press(RIGHT, "after_won", 1, 0, 1, 0, 0);

    // Request and busy in the same cycle: busy wins.
    maze_busy = 1'b1;
    btns = RIGHT;
    cyc_expect("busy_wins", 0, 0, 0, 0, 0);
    btns = 4'd0;
    maze_busy = 1'b0;
    cyc_expect("busy_wins_after", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
